// File: rtl/spi_ram_irq.sv
// rtl/spi_ram_irq.sv - SPI register windows, IRQ status/mask, debounced buttons, request FIFO
module spi_ram_irq #(
    parameter int         C_ADDR_BITS     = 32,
    parameter int         C_BTN_BITS      = 7,
    parameter int         C_DEBOUNCE_BITS = 20,
    parameter int         C_REQ_CHANNELS  = 2,
    parameter int         C_FIFO_LOG2     = 2,
    parameter logic [7:0] C_ADDR_REQ      = 8'hD0,
    parameter logic [7:0] C_ADDR_IRQ      = 8'hF1,
    parameter logic [7:0] C_ADDR_MASK     = 8'hF2,
    parameter logic [7:0] C_ADDR_BTN      = 8'hFB
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bus_rd,
    input  logic                          bus_wr,
    input  logic [C_ADDR_BITS-1:0]        bus_addr,
    input  logic [7:0]                    bus_wdata,
    output logic [7:0]                    bus_rdata,
    output logic                          ram_rd,
    output logic                          ram_wr,
    input  logic [7:0]                    ram_rdata,
    input  logic [C_BTN_BITS-1:0]         btn,
    input  logic [C_REQ_CHANNELS-1:0]     req,
    input  logic [8*C_REQ_CHANNELS-1:0]   req_type,
    output logic                          irq
);
    localparam int DEPTH = 1 << C_FIFO_LOG2;
    localparam logic [C_FIFO_LOG2:0] FULL_CNT = DEPTH[C_FIFO_LOG2:0];

    logic [7:0] win;
    logic       win_req, win_irq, win_mask, win_btn, win_reg;
    logic       unused_addr;

    assign win         = bus_addr[C_ADDR_BITS-1 -: 8];
    assign win_req     = (win == C_ADDR_REQ);
    assign win_irq     = (win == C_ADDR_IRQ);
    assign win_mask    = (win == C_ADDR_MASK);
    assign win_btn     = (win == C_ADDR_BTN);
    assign win_reg     = win_req | win_irq | win_mask | win_btn;
    assign ram_rd      = bus_rd & ~win_reg;
    assign ram_wr      = bus_wr & ~win_reg;
    assign unused_addr = &{1'b0, bus_addr[C_ADDR_BITS-9:1]};

    // Side effects act on the read strobe's falling edge, using the address seen while it was high
    logic       rd_d, rd_a0, rd_fall, clr_flags, pop;
    logic [7:0] rd_win;
    logic [7:0] mask;

    logic [C_BTN_BITS-1:0]      btn_latch, btn_state;
    logic [C_DEBOUNCE_BITS-1:0] db_cnt;
    logic                       btn_flag, btn_set, ovf_flag, ovf_set;

    logic [C_REQ_CHANNELS-1:0]   req_q, req_q2, req_rise, pend, grant;
    logic [8*C_REQ_CHANNELS-1:0] type_q;
    logic [7:0]                  ptype [C_REQ_CHANNELS];
    logic [2:0]                  gnt_idx;
    logic [7:0]                  gnt_type;
    logic                        any_pend, push_ok, drop;

    logic [10:0]            mem [DEPTH];
    logic [C_FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [C_FIFO_LOG2:0]   count;
    logic                   empty;
    logic [3:0]             cnt4;
    logic [2:0]             head_ch;
    logic [7:0]             head_type, status;

    assign rd_fall   = rd_d & ~bus_rd;
    assign clr_flags = rd_fall && (rd_win == C_ADDR_IRQ);
    assign empty     = (count == '0);
    assign pop       = rd_fall && (rd_win == C_ADDR_REQ) && rd_a0 && !empty;
    assign btn_set   = (btn_latch != btn_state) && db_cnt[C_DEBOUNCE_BITS-1] && !btn_flag;
    assign req_rise  = req_q & ~req_q2;
    assign push_ok   = any_pend && (count != FULL_CNT);
    assign drop      = any_pend && (count == FULL_CNT);
    // A channel granted this cycle is being drained, so a fresh edge on it is not an overrun
    assign ovf_set   = drop | (|(req_rise & pend & ~grant));
    assign head_ch   = empty ? 3'd0 : mem[rd_ptr][10:8];
    assign head_type = empty ? 8'd0 : mem[rd_ptr][7:0];
    assign cnt4      = 4'(count);
    assign status    = {btn_flag, 5'b0, ovf_flag, ~empty};

    always_comb begin
        any_pend = 1'b0;
        gnt_idx  = 3'd0;
        gnt_type = 8'd0;
        grant    = '0;
        for (int i = C_REQ_CHANNELS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                any_pend = 1'b1;
                gnt_idx  = 3'(i);
                gnt_type = ptype[i];
            end
        end
        for (int i = 0; i < C_REQ_CHANNELS; i++) begin
            grant[i] = any_pend && (gnt_idx == 3'(i));
        end
    end

    always_comb begin
        bus_rdata = ram_rdata;
        if (win_irq)       bus_rdata = status;
        else if (win_mask) bus_rdata = mask;
        else if (win_btn)  bus_rdata = 8'(btn_state);
        else if (win_req)  bus_rdata = bus_addr[0] ? head_type : {cnt4, 1'b0, head_ch};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_d      <= 1'b0;
            rd_win    <= 8'd0;
            rd_a0     <= 1'b0;
            mask      <= 8'h83;
            irq       <= 1'b0;
            btn_latch <= '0;
            btn_state <= '0;
            db_cnt    <= '0;
            btn_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
            req_q     <= '0;
            req_q2    <= '0;
            type_q    <= '0;
            pend      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            rd_d <= bus_rd;
            if (bus_rd) begin
                rd_win <= win;
                rd_a0  <= bus_addr[0];
            end
            if (bus_wr && win_mask) mask <= bus_wdata;
            irq <= |(status & mask);

            btn_latch <= btn;
            if (btn_set) begin
                btn_state <= btn_latch;
                db_cnt    <= '0;
            end else if (!db_cnt[C_DEBOUNCE_BITS-1]) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (btn_set)        btn_flag <= 1'b1;
            else if (clr_flags) btn_flag <= 1'b0;
            if (ovf_set)        ovf_flag <= 1'b1;
            else if (clr_flags) ovf_flag <= 1'b0;

            req_q  <= req;
            req_q2 <= req_q;
            type_q <= req_type;
            for (int i = 0; i < C_REQ_CHANNELS; i++) begin
                if (req_rise[i]) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= type_q[8*i +: 8];
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            if (push_ok) begin
                mem[wr_ptr] <= {gnt_idx, gnt_type};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_ram_irq.sv
// tb/tb_spi_ram_irq.sv - directed self-checking bench for spi_ram_irq
module tb_spi_ram_irq;
    logic        clk = 1'b0;
    logic        reset;
    logic        bus_rd, bus_wr;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata, ram_rdata;
    logic        ram_rd, ram_wr, irq;
    logic [6:0]  btn;
    logic [1:0]  req;
    logic [15:0] req_type;

    int errors = 0;
    int checks = 0;

    spi_ram_irq #(.C_DEBOUNCE_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rdata(ram_rdata),
        .btn(btn), .req(req), .req_type(req_type), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_byte(input logic [31:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_rd   = 1'b1;
        #1;
        d = bus_rdata;
        tick(1);
        bus_rd = 1'b0;
        tick(1);
    endtask

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] v);
        bus_addr  = a;
        bus_wdata = v;
        bus_wr    = 1'b1;
        tick(1);
        bus_wr = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        rd_byte(32'hF1000000, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", d); end
        rd_byte(32'hF2000000, d);
        checks++; if (d !== 8'h83) begin errors++; $display("FAIL reset_mask got=%h exp=83", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_ram_passthru;
        bus_addr = 32'h00000010;
        bus_rd   = 1'b1;
        #1;
        checks++; if (bus_rdata !== 8'h5A || ram_rd !== 1'b1) begin
            errors++; $display("FAIL ram_read rdata=%h ram_rd=%b exp=5a/1", bus_rdata, ram_rd);
        end
        bus_addr = 32'hF1000000;
        #1;
        checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL ram_rd_gated got=%b exp=0", ram_rd); end
        tick(1);
        bus_rd = 1'b0;
        tick(1);
    endtask

    task automatic test_single_req;
        logic [7:0] d;
        int n;
        req_type = {8'h25, 8'h00};
        req = 2'b10;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            req = 2'b00;
            if (irq === 1'b1) begin n = i; break; end
        end
        checks++; if (n == 0 || n > 4) begin errors++; $display("FAIL single_irq_latency got=%0d exp<=4", n); end
        rd_byte(32'hD0000000, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL single_head got=%h exp=11", d); end
        rd_byte(32'hD0000001, d);
        checks++; if (d !== 8'h25) begin errors++; $display("FAIL single_type got=%h exp=25", d); end
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_clear got=%b exp=0", irq); end
        rd_byte(32'hD0000000, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL single_drained got=%h exp=00", d); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        req_type = {8'hB1, 8'hA0};
        req = 2'b11;
        tick(1);
        req = 2'b00;
        tick(6);
        rd_byte(32'hD0000000, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL b2b_head0 got=%h exp=20", d); end
        rd_byte(32'hD0000001, d);
        checks++; if (d !== 8'hA0) begin errors++; $display("FAIL b2b_type0 got=%h exp=a0", d); end
        rd_byte(32'hD0000000, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL b2b_head1 got=%h exp=11", d); end
        rd_byte(32'hD0000001, d);
        checks++; if (d !== 8'hB1) begin errors++; $display("FAIL b2b_type1 got=%h exp=b1", d); end
        rd_byte(32'hF1000000, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL b2b_status got=%h exp=00", d); end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        for (int k = 0; k < 5; k++) begin
            req_type = {8'h00, 8'h40 + 8'(k)};
            req = 2'b01;
            tick(1);
            req = 2'b00;
            tick(4);
        end
        tick(3);
        rd_byte(32'hF1000000, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL ovf_status got=%h exp=03", d); end
        rd_byte(32'hF1000000, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL ovf_cleared got=%h exp=01", d); end
        rd_byte(32'hD0000000, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL ovf_count got=%h exp=40", d); end
        rd_byte(32'hD0000001, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL ovf_first_type got=%h exp=40", d); end
        rd_byte(32'hD0000001, d);
        checks++; if (d !== 8'h41) begin errors++; $display("FAIL ovf_second_type got=%h exp=41", d); end
    endtask

    task automatic test_mask_and_reset;
        logic [7:0] d;
        bus_addr  = 32'hF2000000;
        bus_wdata = 8'h00;
        bus_wr    = 1'b1;
        #1;
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL ram_wr_gated got=%b exp=0", ram_wr); end
        tick(1);
        bus_wr = 1'b0;
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_off_irq got=%b exp=0", irq); end
        wr_byte(32'hF2000000, 8'h01);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_on_irq got=%b exp=1", irq); end
        rd_byte(32'hF2000000, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL mask_readback got=%h exp=01", d); end
        reset = 1'b1;
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_mid got=%b exp=0", irq); end
        reset = 1'b0;
        tick(1);
        rd_byte(32'hD0000000, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", d); end
    endtask

    task automatic test_buttons;
        logic [7:0] d;
        int n;
        btn = 7'h05;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (irq === 1'b1) begin n = i; break; end
        end
        checks++; if (n == 0) begin errors++; $display("FAIL btn_irq timeout got=0 exp=1"); end
        rd_byte(32'hFB000000, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL btn_state got=%h exp=05", d); end
        btn = 7'h06;
        tick(20);
        rd_byte(32'hFB000000, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL btn_held got=%h exp=05", d); end
        rd_byte(32'hF1000000, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL btn_status got=%h exp=80", d); end
        tick(3);
        rd_byte(32'hFB000000, d);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL btn_second got=%h exp=06", d); end
        rd_byte(32'hF1000000, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL btn_status2 got=%h exp=80", d); end
    endtask

    initial begin
        reset     = 1'b1;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 8'h0;
        ram_rdata = 8'h5A;
        btn       = 7'h00;
        req       = 2'b00;
        req_type  = 16'h0;
        test_reset();
        test_ram_passthru();
        test_single_req();
        test_back_to_back();
        test_overflow();
        test_mask_and_reset();
        test_buttons();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
